// File: rtl/win_screen_pkg.sv
// Shared types and constants for the win-screen overlay controller.
package win_screen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FADE_IN,
    S_HOLD,
    S_FADE_OUT
  } state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

endpackage

// File: rtl/color_blend4.sv
// One 4-bit colour channel cross-faded between board and picture by a 0..16 level.
module color_blend4
  import win_screen_pkg::*;
(
  input  logic [3:0] pic,
  input  logic [3:0] board,
  input  logic [4:0] level,
  output logic [3:0] mix
);

  // The two weights always sum to 16, so the 9-bit sum tops out at 240.
  function automatic logic [3:0] blend(input logic [3:0] p, input logic [3:0] b,
                                       input logic [4:0] l);
    logic [8:0] acc;
    acc = 9'(p) * 9'(l) + 9'(b) * 9'(LEVEL_MAX - l);
    return 4'(acc >> 4);
  endfunction

  assign mix = blend(pic, board, level);

endmodule

// File: rtl/win_screen_ctrl.sv
// Win-screen overlay: frame-synchronous level sequencer plus per-pixel blend.
// Define WIN_SCREEN_FADE_EN for gradual fade in/out; otherwise the picture cuts in and out.
module win_screen_ctrl
  import win_screen_pkg::*;
#(
  parameter int HOLD_FRAMES = 180,
  parameter int STEP_FRAMES = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       win_req,
  input  logic       dismiss,
  input  logic [3:0] board_r,
  input  logic [3:0] board_g,
  input  logic [3:0] board_b,
  input  logic [3:0] pic_r,
  input  logic [3:0] pic_g,
  input  logic [3:0] pic_b,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       overlay_active,
  output logic [4:0] level
);

  localparam int CNT_MAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES);
`ifdef WIN_SCREEN_FADE_EN
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             origin;
  logic             origin_p0;
  logic             frame_tick;
  logic [3:0]       mix_r, mix_g, mix_b;

  assign origin         = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_tick     = origin && !origin_p0;
  assign cnt_nxt        = cnt + CNT_ONE;
  assign overlay_active = (state != S_IDLE);

  color_blend4 u_blend_r (.pic(pic_r), .board(board_r), .level(level), .mix(mix_r));
  color_blend4 u_blend_g (.pic(pic_g), .board(board_g), .level(level), .mix(mix_g));
  color_blend4 u_blend_b (.pic(pic_b), .board(board_b), .level(level), .mix(mix_b));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      level     <= '0;
      cnt       <= '0;
      origin_p0 <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      origin_p0 <= origin;
      // Output stage: blended pixel registered, forced black outside the visible area.
      red       <= blank ? mix_r : 4'd0;
      green     <= blank ? mix_g : 4'd0;
      blue      <= blank ? mix_b : 4'd0;

      case (state)
`ifdef WIN_SCREEN_FADE_EN
        S_IDLE: begin
          if (win_req) begin
            state <= S_FADE_IN;
            level <= '0;
            cnt   <= '0;
          end
        end
        S_FADE_IN: begin
          if (dismiss) begin
            state <= S_FADE_OUT;
            cnt   <= '0;
          end else if (frame_tick) begin
            if (cnt_nxt == STEP_LAST) begin
              cnt   <= '0;
              level <= level + 5'd1;
              if (level == LEVEL_MAX - 5'd1) state <= S_HOLD;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        S_HOLD: begin
          // Dismiss and expiry lead to the same full-level fade-out entry.
          if (dismiss || (frame_tick && cnt_nxt == HOLD_LAST)) begin
            state <= S_FADE_OUT;
            cnt   <= '0;
          end else if (frame_tick) begin
            cnt <= cnt_nxt;
          end
        end
        S_FADE_OUT: begin
          if (frame_tick) begin
            if (cnt_nxt == STEP_LAST) begin
              cnt <= '0;
              if (level <= 5'd1) begin
                state <= S_IDLE;
                level <= '0;
              end else begin
                level <= level - 5'd1;
              end
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        default: state <= S_IDLE;
`else
        S_IDLE: begin
          if (win_req) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end
        S_HOLD: begin
          // Level snaps to full on the first tick so the cut lands on a frame boundary.
          if (dismiss || (frame_tick && cnt_nxt == HOLD_LAST)) begin
            state <= S_IDLE;
            level <= '0;
            cnt   <= '0;
          end else if (frame_tick) begin
            level <= LEVEL_MAX;
            cnt   <= cnt_nxt;
          end
        end
        default: state <= S_IDLE;
`endif
      endcase
    end
  end

endmodule

// File: doc/win_screen_ctrl.md
WIN_SCREEN_CTRL -- requirements
Module: win_screen_ctrl

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 180, number of frames the win picture is held at full level.
REQ-002 SHALL have parameter STEP_FRAMES, default 2, number of frames per fade level step.
REQ-003 SHALL have port vga_clk  in  1  pixel clock; the sole clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port DrawX  in  10  current pixel column.
REQ-006 SHALL have port DrawY  in  10  current pixel row.
REQ-007 SHALL have port blank  in  1  high during the visible region.
REQ-008 SHALL have port win_req  in  1  single-cycle request to show the win screen.
REQ-009 SHALL have port dismiss  in  1  single-cycle request to leave the win screen early.
REQ-010 SHALL have ports board_r, board_g, board_b  in  4 each  game-board pixel colour.
REQ-011 SHALL have ports pic_r, pic_g, pic_b  in  4 each  win-picture pixel colour.
REQ-012 SHALL have ports red, green, blue  out  4 each  registered blended pixel colour.
REQ-013 SHALL have port overlay_active  out  1  high in any state other than IDLE.
REQ-014 SHALL have port level  out  5  current blend level, 0..16.

Function
REQ-015 SHALL raise frame_tick for exactly one cycle on the first cycle where DrawX==0 and DrawY==0 after any cycle where that condition did not hold.
REQ-016 SHALL implement states IDLE, FADE_IN, HOLD and FADE_OUT.
REQ-017 SHALL move IDLE->FADE_IN on win_req, with level=0 and the frame counter cleared.
REQ-018 SHALL, in FADE_IN, increment level by 1 every STEP_FRAMES frame_ticks, and enter HOLD on the tick that makes level 16.
REQ-019 SHALL, in HOLD, count HOLD_FRAMES frame_ticks and then enter FADE_OUT.
REQ-020 SHALL, in FADE_OUT, decrement level by 1 every STEP_FRAMES frame_ticks, and enter IDLE on the tick that makes level 0.
REQ-021 SHALL, on dismiss in FADE_IN or HOLD, enter FADE_OUT starting from the current level and clear the frame counter.
REQ-022 SHALL ignore dismiss in IDLE and FADE_OUT.
REQ-023 SHALL ignore win_req in every state except IDLE.
REQ-024 SHALL give dismiss priority over the HOLD expiry if both occur in the same cycle; the outcome is the same FADE_OUT entry.
REQ-025 SHALL compute each channel as (pic*level + board*(16-level)) >> 4, with 9-bit intermediate width and no overflow.
REQ-026 SHALL register red, green and blue on vga_clk with one cycle of latency from the inputs.
REQ-027 SHALL drive red, green and blue to 0 when blank is low.
REQ-028 SHALL pass the board colour unchanged in IDLE (level==0).
REQ-029 SHALL update level only on frame_tick, so that no frame shows mixed levels.

Reset
REQ-030 SHALL, while reset is high, force state=IDLE, level=0, frame counter=0, red=green=blue=0, overlay_active=0, and clear the frame_tick edge-detect history.
REQ-031 SHALL, on reset asserted mid-fade, return to IDLE in the next cycle with no fade-out.

Configuration
REQ-032 SHALL, with WIN_SCREEN_FADE_EN defined, implement the fade behaviour above.
REQ-033 SHALL, without WIN_SCREEN_FADE_EN, skip FADE_IN and FADE_OUT: IDLE->HOLD with level=16 on win_req, and HOLD->IDLE with level=0 on expiry or dismiss; STEP_FRAMES is then unused.

Structure
REQ-034 SHALL define the state enum type and the 16-level constant in the shared package win_screen_pkg.
REQ-035 SHALL place the per-channel blend in a sub-module color_blend4, instantiated three times.

Verification
REQ-036 SHALL cover: win_req in IDLE, STEP_FRAMES=2 -> level reaches 16 after 32 frame_ticks, overlay_active=1 throughout.
REQ-037 SHALL cover: HOLD_FRAMES=3 -> FADE_OUT begins on the 3rd tick in HOLD and IDLE is reached 32 ticks later with level=0.
REQ-038 SHALL cover: pic=4'hF, board=4'h0, level=8 -> output channel is 4'h7; level=16 -> 4'hF; blank=0 -> 4'h0.
REQ-039 SHALL cover: dismiss at level 5 in FADE_IN -> FADE_OUT from 5, reaching IDLE after 10 ticks; a second win_req during FADE_OUT is ignored.
REQ-040 SHALL cover: reset held for one cycle during HOLD -> next cycle has state IDLE, outputs 0, overlay_active=0.
REQ-041 SHALL cover: WIN_SCREEN_FADE_EN undefined, win_req -> level=16 on the next frame_tick, HOLD, then level=0 directly.
